snn_neuron_ctrl: RTL and testbench

Clocked controller for one integrate-and-fire neuron. It sequences the shared partial-sum adder and membrane register across a timestep: it accepts `NUM_PSUM` 8-bit partial sums over a valid/ready handshake and accumulates them into a 13-bit membrane potential. It then compares the potential against a threshold and emits one spike/no-spike token per timestep to the downstream spike router.

---
 rtl/snn_pkg.sv | 15 +
 rtl/psum_accum.sv | 68 ++++++
 rtl/snn_neuron_ctrl.sv | 98 +++++++++
 tb/tb_snn_neuron_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the integrate-and-fire neuron controller.
package snn_pkg;

  localparam int WIDTH_IN_DEF  = 8;
  localparam int WIDTH_OUT_DEF = 13;

  localparam logic [WIDTH_OUT_DEF-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FIRE  = 2'd1,
    SEND  = 2'd2
  } neuron_state_t;

endpackage

// File: rtl/psum_accum.sv
// Saturating partial-sum adder and membrane register with add, fire-subtract and clear.
// Optional leak in the fire step is enabled by defining SNN_LEAK_EN.
module psum_accum
  import snn_pkg::*;
#(
  parameter int WIDTH_IN  = WIDTH_IN_DEF,
  parameter int WIDTH_OUT = WIDTH_OUT_DEF,
  parameter int LEAK      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 add_en,
  input  logic [WIDTH_IN-1:0]  add_data,
  input  logic                 fire_en,
  input  logic [WIDTH_OUT-1:0] threshold,
  output logic                 fire,
  output logic [WIDTH_OUT-1:0] mem
);

  localparam logic [WIDTH_OUT-1:0] MEM_MAX = '1;

  if (LEAK < 0 || LEAK >= 2**WIDTH_OUT || WIDTH_IN > WIDTH_OUT) begin : g_bad_params
    $error("psum_accum: LEAK or width parameters out of range");
  end

  // Carry out of the widened sum clamps to full scale instead of wrapping.
  function automatic logic [WIDTH_OUT-1:0] sat_add(input logic [WIDTH_OUT-1:0] a,
                                                   input logic [WIDTH_IN-1:0]  b);
    logic [WIDTH_OUT:0] sum;
    sum = {1'b0, a} + (WIDTH_OUT+1)'(b);
    return sum[WIDTH_OUT] ? MEM_MAX : sum[WIDTH_OUT-1:0];
  endfunction

`ifdef SNN_LEAK_EN
  localparam logic [WIDTH_OUT-1:0] LEAK_AMT = WIDTH_OUT'(LEAK);

  function automatic logic [WIDTH_OUT-1:0] leak_step(input logic [WIDTH_OUT-1:0] a);
    return (a > LEAK_AMT) ? a - LEAK_AMT : '0;
  endfunction
`endif

  logic [WIDTH_OUT-1:0] thr_res;
  logic [WIDTH_OUT-1:0] fire_res;

  always_comb begin
    fire    = (mem >= threshold);
    thr_res = fire ? mem - threshold : mem;
`ifdef SNN_LEAK_EN
    fire_res = leak_step(thr_res);
`else
    fire_res = thr_res;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (clear) begin
      mem <= '0;
    end else if (fire_en) begin
      mem <= fire_res;
    end else if (add_en) begin
      mem <= sat_add(mem, add_data);
    end
  end

endmodule

// File: rtl/snn_neuron_ctrl.sv
// Integrate-and-fire neuron controller: accumulates NUM_PSUM partial sums, fires, sends one token.
// Defining SNN_LEAK_EN adds a per-timestep leak of LEAK in the FIRE step.
module snn_neuron_ctrl
  import snn_pkg::*;
#(
  parameter int WIDTH_IN  = WIDTH_IN_DEF,
  parameter int WIDTH_OUT = WIDTH_OUT_DEF,
  parameter int NUM_PSUM  = 4,
  parameter int LEAK      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH_IN-1:0]  psum_data,
  input  logic                 psum_valid,
  output logic                 psum_ready,
  input  logic [WIDTH_OUT-1:0] threshold,
  output logic                 spike_valid,
  output logic                 spike,
  input  logic                 spike_ready,
  output logic [WIDTH_OUT-1:0] mem_pot
);

  if (NUM_PSUM < 1 || NUM_PSUM > 255) begin : g_bad_num_psum
    $error("snn_neuron_ctrl: NUM_PSUM must be in 1..255");
  end

  neuron_state_t state;
  logic [7:0]    cnt;
  logic          psum_hs;
  logic          spike_hs;
  logic          last_psum;
  logic          fire;
  logic          fire_en;

  assign psum_hs   = psum_valid && psum_ready;
  assign spike_hs  = spike_valid && spike_ready;
  assign last_psum = psum_hs && (cnt == 8'(NUM_PSUM - 1));
  assign fire_en   = (state == FIRE);

  psum_accum #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT),
    .LEAK      (LEAK)
  ) u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (1'b0),
    .add_en    (psum_hs),
    .add_data  (psum_data),
    .fire_en   (fire_en),
    .threshold (threshold),
    .fire      (fire),
    .mem       (mem_pot)
  );

  // psum_ready is registered, so it is only ever high while sitting in ACCUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      cnt         <= '0;
      psum_ready  <= 1'b0;
      spike_valid <= 1'b0;
      spike       <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          psum_ready <= 1'b1;
          if (psum_hs) begin
            if (last_psum) begin
              cnt        <= '0;
              psum_ready <= 1'b0;
              state      <= FIRE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        FIRE: begin
          spike       <= fire;
          spike_valid <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (spike_hs) begin
            spike_valid <= 1'b0;
            psum_ready  <= 1'b1;
            state       <= ACCUM;
          end
        end
        default: begin
          state      <= ACCUM;
          psum_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_neuron_ctrl.sv
// Self-checking bench for snn_neuron_ctrl: directed and randomized timesteps against a behavioural model.
module tb_snn_neuron_ctrl;

  localparam int NP     = 4;
  localparam int LEAK_V = 5;
  localparam int MAXV   = 8191;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  psum_data = '0;
  logic        psum_valid = 1'b0;
  logic        psum_ready;
  logic [12:0] threshold = '0;
  logic        spike_valid;
  logic        spike;
  logic        spike_ready = 1'b0;
  logic [12:0] mem_pot;

  int total = 0;
  int bad   = 0;
  int m     = 0;
  int ps[NP];

  always #5 clk = ~clk;

  snn_neuron_ctrl #(
    .WIDTH_IN  (8),
    .WIDTH_OUT (13),
    .NUM_PSUM  (NP),
    .LEAK      (LEAK_V)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .psum_data   (psum_data),
    .psum_valid  (psum_valid),
    .psum_ready  (psum_ready),
    .threshold   (threshold),
    .spike_valid (spike_valid),
    .spike       (spike),
    .spike_ready (spike_ready),
    .mem_pot     (mem_pot)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference neuron: integer membrane, clamp on add, threshold then optional leak.
  function automatic void model_add(input int d);
    m = m + d;
    if (m > MAXV) m = MAXV;
  endfunction

  function automatic int model_fire(input int thr);
    int fired;
    fired = (m >= thr) ? 1 : 0;
    if (fired != 0) m = m - thr;
`ifdef SNN_LEAK_EN
    m = (m > LEAK_V) ? m - LEAK_V : 0;
`endif
    return fired;
  endfunction

  task automatic push(input int d, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    psum_valid = 1'b1;
    psum_data  = 8'(d);
    while (!psum_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("push_ready_timeout", 32'(psum_ready), 32'd1);
    @(posedge clk);
    #1;
    psum_valid = 1'b0;
    model_add(d);
  endtask

  task automatic timestep(input string tag, input int thr, input int stall, input int gap_max);
    int exp_sp;
    threshold = 13'(thr);
    for (int i = 0; i < NP; i++) push(ps[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    @(negedge clk);
    chk({tag, "_fire_sv"}, 32'(spike_valid), 32'd0);
    chk({tag, "_fire_rdy"}, 32'(psum_ready), 32'd0);
    exp_sp = model_fire(thr);
    @(negedge clk);
    chk({tag, "_sv"}, 32'(spike_valid), 32'd1);
    chk({tag, "_spike"}, 32'(spike), 32'(exp_sp));
    chk({tag, "_mem"}, 32'(mem_pot), 32'(m));
    for (int k = 0; k < stall; k++) begin
      psum_valid = 1'b1;
      psum_data  = 8'($urandom);
      @(negedge clk);
      chk({tag, "_bp_sv"}, 32'(spike_valid), 32'd1);
      chk({tag, "_bp_spike"}, 32'(spike), 32'(exp_sp));
      chk({tag, "_bp_rdy"}, 32'(psum_ready), 32'd0);
      chk({tag, "_bp_mem"}, 32'(mem_pot), 32'(m));
    end
    psum_valid  = 1'b0;
    spike_ready = 1'b1;
    @(negedge clk);
    spike_ready = 1'b0;
    chk({tag, "_done_sv"}, 32'(spike_valid), 32'd0);
    chk({tag, "_done_rdy"}, 32'(psum_ready), 32'd1);
    chk({tag, "_done_mem"}, 32'(mem_pot), 32'(m));
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_mem"}, 32'(mem_pot), 32'd0);
    chk({tag, "_rdy"}, 32'(psum_ready), 32'd0);
    chk({tag, "_sv"}, 32'(spike_valid), 32'd0);
    m = 0;
    @(negedge clk);
    psum_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_rel_rdy"}, 32'(psum_ready), 32'd1);
  endtask

  initial begin
    // Reset held with a valid psum present.
    rst_n      = 1'b0;
    psum_valid = 1'b1;
    psum_data  = 8'hAA;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(psum_ready), 32'd0);
    chk("rst_sv", 32'(spike_valid), 32'd0);
    chk("rst_spike", 32'(spike), 32'd0);
    chk("rst_mem", 32'(mem_pot), 32'd0);
    psum_valid = 1'b0;
    rst_n      = 1'b1;
    #1;
    chk("rel_rdy_low", 32'(psum_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_rdy_high", 32'(psum_ready), 32'd1);
    m = 0;

    ps = '{10, 20, 30, 40};
    timestep("fire", 90, 0, 0);

    pulse_reset("rst_a");
    ps = '{10, 20, 30, 40};
    timestep("nofire", 200, 0, 0);
    ps = '{25, 25, 25, 25};
    timestep("fire2", 200, 0, 0);

    pulse_reset("rst_b");
    ps = '{255, 255, 255, 255};
    for (int t = 0; t < 10; t++) timestep("sat", MAXV, 0, 0);

    ps = '{1, 2, 3, 4};
    timestep("thr0", 0, 0, 0);
    ps = '{1, 2, 3, 4};
    timestep("bp", 5, 5, 0);

    // Reset in the middle of a timestep discards the partial sum.
    pulse_reset("rst_c");
    push(100, 0);
    push(100, 0);
    chk("mid_mem", 32'(mem_pot), 32'(m));
    pulse_reset("rst_mid");
    ps = '{5, 10, 15, 20};
    timestep("fresh", 90, 0, 0);

    for (int t = 0; t < 25; t++) begin
      int thr;
      for (int i = 0; i < NP; i++) ps[i] = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      thr = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 1200));
      timestep("rand", thr, int'($urandom_range(0, 3)), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation timeout");
  end

endmodule
